// File: rtl/border_detector_if.sv
// Signal bundle between the border detector, the tile-map ROM and the ball mover.
// The slave side is the detector itself; the master side drives the frame inputs and ROM data.
interface border_detector_if;
  logic        frame_start;
  logic [9:0]  BallX;
  logic [9:0]  BallY;
  logic [9:0]  BallS;
  logic [1:0]  level;
  logic [11:0] tile_addr;
  logic        tile_rd;
  logic        tile_wall;
  logic        Ball_At_Border_Top;
  logic        Ball_At_Border_Bottom;
  logic        Ball_At_Border_Left;
  logic        Ball_At_Border_Right;
  logic        busy;
  logic        check_done;
  logic        overrun;

  modport master (
    output frame_start, BallX, BallY, BallS, level, tile_wall,
    input  tile_addr, tile_rd, Ball_At_Border_Top, Ball_At_Border_Bottom,
           Ball_At_Border_Left, Ball_At_Border_Right, busy, check_done, overrun
  );

  modport slave (
    input  frame_start, BallX, BallY, BallS, level, tile_wall,
    output tile_addr, tile_rd, Ball_At_Border_Top, Ball_At_Border_Bottom,
           Ball_At_Border_Left, Ball_At_Border_Right, busy, check_done, overrun
  );
endinterface

// File: rtl/border_detector.sv
// Per-frame ball border check: probes the eight tiles just outside the ball's bounding box
// in a fixed 12-cycle sequence and publishes the four blocking flags together.
module border_detector #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int MAP_COLS   = 32,
  parameter int TILE_RECIP = 3277,
  parameter int TILE_SHIFT = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  border_detector_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_PROBE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_UPDATE = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [9:0]         x_r;
  logic [9:0]         y_r;
  logic [9:0]         s_r;
  logic [1:0]         level_r;
  logic [2:0]         slot_r;
  logic signed [10:0] px_r [8];
  logic signed [10:0] py_r [8];
  logic signed [10:0] l_s;
  logic signed [10:0] r_s;
  logic signed [10:0] t_s;
  logic signed [10:0] b_s;
  logic signed [10:0] px_s;
  logic signed [10:0] py_s;
  logic               oob_s;
  logic [4:0]         col_s;
  logic [4:0]         row_s;
  logic [11:0]        addr_s;
  logic [11:0]        tile_addr_r;
  logic               tile_rd_r;
  logic               s1_vld_r;
  logic               s1_oob_r;
  logic [1:0]         s1_dir_r;
  logic               s2_vld_r;
  logic               s2_oob_r;
  logic [1:0]         s2_dir_r;
  logic [3:0]         acc_r;
  logic [3:0]         flags_r;
  logic               busy_r;
  logic               check_done_r;
  logic               overrun_r;

  // Divide-by-tile-size via reciprocal multiply; only meaningful for on-screen coordinates.
  function automatic logic [4:0] tile_index(input logic signed [10:0] coord);
    tile_index = 5'((32'($unsigned(coord)) * 32'(TILE_RECIP)) >> TILE_SHIFT);
  endfunction

  // Bounding-box edges from the latched ball geometry.
  always_comb begin
    l_s = $signed({1'b0, x_r}) - $signed({1'b0, s_r});
    r_s = $signed({1'b0, x_r}) + $signed({1'b0, s_r});
    t_s = $signed({1'b0, y_r}) - $signed({1'b0, s_r});
    b_s = $signed({1'b0, y_r}) + $signed({1'b0, s_r});
  end

  // Current probe: screen bounds test and ROM address.
  always_comb begin
    px_s   = px_r[slot_r];
    py_s   = py_r[slot_r];
    oob_s  = px_s[10] || py_s[10] || (int'(px_s) >= SCREEN_W) || (int'(py_s) >= SCREEN_H);
    col_s  = tile_index(px_s);
    row_s  = tile_index(py_s);
    addr_s = {level_r, 10'(32'(row_s) * 32'(MAP_COLS) + 32'(col_s))};
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.frame_start) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC:  state_nxt_s = ST_PROBE;
      ST_PROBE: begin
        if (slot_r == 3'd7) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_PROBE;
        end
      end
      ST_DRAIN: begin
        if (slot_r == 3'd1) begin
          state_nxt_s = ST_UPDATE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_UPDATE: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: latch, probe issue, two-stage read tracking, accumulation and publish.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_r          <= 10'd0;
      y_r          <= 10'd0;
      s_r          <= 10'd0;
      level_r      <= 2'd0;
      slot_r       <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        px_r[i] <= 11'sd0;
        py_r[i] <= 11'sd0;
      end
      tile_addr_r  <= 12'd0;
      tile_rd_r    <= 1'b0;
      s1_vld_r     <= 1'b0;
      s1_oob_r     <= 1'b0;
      s1_dir_r     <= 2'd0;
      s2_vld_r     <= 1'b0;
      s2_oob_r     <= 1'b0;
      s2_dir_r     <= 2'd0;
      acc_r        <= 4'd0;
      flags_r      <= 4'hF;
      busy_r       <= 1'b0;
      check_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      check_done_r <= 1'b0;
      overrun_r    <= bus.frame_start && (state_r != ST_IDLE);
      tile_rd_r    <= 1'b0;
      s1_vld_r     <= 1'b0;
      s2_vld_r     <= s1_vld_r;
      s2_oob_r     <= s1_oob_r;
      s2_dir_r     <= s1_dir_r;
      case (state_r)
        ST_IDLE: begin
          if (bus.frame_start) begin
            x_r     <= bus.BallX;
            y_r     <= bus.BallY;
            s_r     <= bus.BallS;
            level_r <= bus.level;
            acc_r   <= 4'd0;
            busy_r  <= 1'b1;
          end
        end
        ST_CALC: begin
          px_r[0] <= l_s;          py_r[0] <= t_s - 11'sd1;
          px_r[1] <= r_s;          py_r[1] <= t_s - 11'sd1;
          px_r[2] <= l_s;          py_r[2] <= b_s + 11'sd1;
          px_r[3] <= r_s;          py_r[3] <= b_s + 11'sd1;
          px_r[4] <= l_s - 11'sd1; py_r[4] <= t_s;
          px_r[5] <= l_s - 11'sd1; py_r[5] <= b_s;
          px_r[6] <= r_s + 11'sd1; py_r[6] <= t_s;
          px_r[7] <= r_s + 11'sd1; py_r[7] <= b_s;
          slot_r  <= 3'd0;
        end
        ST_PROBE: begin
          slot_r   <= slot_r + 3'd1;
          s1_vld_r <= 1'b1;
          s1_oob_r <= oob_s;
          s1_dir_r <= slot_r[2:1];
          // Off-screen slots skip the read and leave the address bus untouched.
          if (!oob_s) begin
            tile_rd_r   <= 1'b1;
            tile_addr_r <= addr_s;
          end
        end
        ST_DRAIN: begin
          slot_r <= slot_r + 3'd1;
        end
        ST_UPDATE: begin
          flags_r      <= acc_r;
          check_done_r <= 1'b1;
          busy_r       <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
      if (s2_vld_r) begin
        acc_r[s2_dir_r] <= acc_r[s2_dir_r] | s2_oob_r | bus.tile_wall;
      end
    end
  end

  assign bus.tile_addr             = tile_addr_r;
  assign bus.tile_rd               = tile_rd_r;
  assign bus.Ball_At_Border_Top    = flags_r[0];
  assign bus.Ball_At_Border_Bottom = flags_r[1];
  assign bus.Ball_At_Border_Left   = flags_r[2];
  assign bus.Ball_At_Border_Right  = flags_r[3];
  assign bus.busy                  = busy_r;
  assign bus.check_done            = check_done_r;
  assign bus.overrun               = overrun_r;

endmodule
